// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS waveform generator (sine/square/triangle/saw) with glitch-free
// control updates at phase wrap. Optional phase dither enabled by defining DDS_DITHER_EN.
module dds_wave_gen #(
    parameter int                ACC_W      = 32,
    parameter int                PHASE_W    = 8,
    parameter int                DATA_W     = 8,
    parameter logic [ACC_W-1:0]  FTW_FINE   = 32'h0002_0000,
    parameter logic [ACC_W-1:0]  FTW_COARSE = 32'h0100_0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         ctrl_in,
    output logic [PHASE_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [DATA_W-1:0]  wave_out,
    output logic               phase_wrap,
    output logic               running
);

    localparam logic [DATA_W-1:0] MID_SCALE = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         ctrl_q_r;
    logic [2:0]         cfg_r;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   ftw_s;
    logic [ACC_W:0]     sum_s;
    logic               carry_s;
    logic [PHASE_W-1:0] phase_s;
    logic [PHASE_W-1:0] phase_d_r;
    logic [1:0]         sel_d_r;
    logic               act_d_r;
    logic [DATA_W-1:0]  sample_s;

    function automatic logic [DATA_W-1:0] shape(input logic [1:0]         sel,
                                                  input logic [PHASE_W-1:0] p,
                                                  input logic [DATA_W-1:0]  sine);
        case (sel)
            2'd0:    shape = sine;
            2'd1:    shape = {DATA_W{p[PHASE_W-1]}};
            2'd2:    shape = p[PHASE_W-1] ? {~p[PHASE_W-2:0], 1'b0} : {p[PHASE_W-2:0], 1'b0};
            2'd3:    shape = p;
            default: shape = MID_SCALE;
        endcase
    endfunction

    // Tuning word and accumulator sum with carry-out
    always_comb begin
        ftw_s   = cfg_r[2] ? FTW_COARSE : FTW_FINE;
        sum_s   = {1'b0, acc_r} + {1'b0, ftw_s};
        carry_s = sum_s[ACC_W];
    end

`ifdef DDS_DITHER_EN
    logic [15:0]      lfsr_r;
    logic [ACC_W-1:0] dith_s;

    // Galois LFSR for phase dither, advancing only while generating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r <= 16'hACE1;
        end else if (state_r != ST_STOP) begin
            lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Dithered phase truncation; the accumulator itself is never modified
    always_comb begin
        dith_s  = acc_r + {{(ACC_W-16){1'b0}}, lfsr_r};
        phase_s = dith_s[ACC_W-1 -: PHASE_W];
    end
`else
    // Plain phase truncation
    always_comb begin
        phase_s = acc_r[ACC_W-1 -: PHASE_W];
    end
`endif

    // Control FSM: config updates only on a carry so every period is complete
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q_r   <= 4'd0;
            state_r    <= ST_STOP;
            cfg_r      <= 3'd0;
            acc_r      <= {ACC_W{1'b0}};
            phase_wrap <= 1'b0;
            running    <= 1'b0;
        end else begin
            ctrl_q_r <= ctrl_in;
            case (state_r)
                ST_STOP: begin
                    acc_r      <= {ACC_W{1'b0}};
                    phase_wrap <= 1'b0;
                    if (ctrl_q_r[3]) begin
                        cfg_r   <= ctrl_q_r[2:0];
                        state_r <= ST_RUN;
                        running <= 1'b1;
                    end else begin
                        running <= 1'b0;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    acc_r      <= sum_s[ACC_W-1:0];
                    phase_wrap <= carry_s;
                    if (ctrl_q_r[3]) begin
                        state_r <= ST_RUN;
                        running <= 1'b1;
                        if (carry_s) begin
                            cfg_r <= ctrl_q_r[2:0];
                        end
                    end else if (carry_s) begin
                        // Period finished with run deasserted: stop cleanly at phase zero
                        state_r <= ST_STOP;
                        acc_r   <= {ACC_W{1'b0}};
                        running <= 1'b0;
                    end else begin
                        state_r <= ST_DRAIN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_STOP;
                    acc_r      <= {ACC_W{1'b0}};
                    phase_wrap <= 1'b0;
                    running    <= 1'b0;
                end
            endcase
        end
    end

    // Waveform shaping from the delayed phase and select, aligned with ROM data
    always_comb begin
        sample_s = shape(sel_d_r, phase_d_r, rom_data);
    end

    // Two-stage output pipeline; an inactive stage flushes to mid-scale
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= {PHASE_W{1'b0}};
            phase_d_r <= {PHASE_W{1'b0}};
            sel_d_r   <= 2'd0;
            act_d_r   <= 1'b0;
            wave_out  <= MID_SCALE;
        end else begin
            rom_addr  <= phase_s;
            phase_d_r <= phase_s;
            sel_d_r   <= cfg_r[1:0];
            act_d_r   <= (state_r != ST_STOP);
            wave_out  <= act_d_r ? sample_s : MID_SCALE;
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Testbench for dds_wave_gen: directed vector table, corner sequences and randomized
// control changes, all checked against a cycle-level behavioural model.
module tb_dds_wave_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] ctrl_in;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] wave_out;
    logic       phase_wrap;
    logic       running;

    logic [7:0] rom [256];

    int errors = 0;
    int checks = 0;

    // Model state
    int         m_state;   // 0 stopped, 1 running, 2 draining
    logic [3:0] m_q;
    logic [2:0] m_cfg;
    longint     m_acc;
    logic [7:0] s_d0, s_d1, p_d0;
    logic [7:0] exp_wave, exp_rom;
    bit         exp_wrap, exp_run;

    dds_wave_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ctrl_in    (ctrl_in),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .wave_out   (wave_out),
        .phase_wrap (phase_wrap),
        .running    (running)
    );

    always #5 clk = ~clk;

    // Address is registered inside the DUT, so data is valid during the following cycle
    assign rom_data = rom[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ideal(input int st, input logic [2:0] cfg, input longint acc);
        int p;
        p = int'(acc >> 24);
        if (st == 0) return 8'h80;
        case (cfg[1:0])
            2'd0:    return rom[p];
            2'd1:    return (p >= 128) ? 8'hFF : 8'h00;
            2'd2:    return (p < 128) ? 8'(2 * p) : 8'(2 * (255 - p));
            default: return 8'(p);
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_q = 4'd0; m_cfg = 3'd0; m_acc = 0;
        s_d0 = 8'h80; s_d1 = 8'h80; p_d0 = 8'h00;
        exp_wave = 8'h80; exp_rom = 8'h00; exp_wrap = 1'b0; exp_run = 1'b0;
    endtask

    task automatic model_step();
        longint ftw, sum;
        bit     carry;
        carry = 1'b0;
        ftw   = m_cfg[2] ? 64'd16777216 : 64'd131072;
        if (m_state == 0) begin
            m_acc = 0;
            if (m_q[3]) begin
                m_cfg   = m_q[2:0];
                m_state = 1;
            end
        end else begin
            sum   = m_acc + ftw;
            carry = (sum >= 64'd4294967296);
            m_acc = sum % 64'd4294967296;
            if (m_q[3]) begin
                m_state = 1;
                if (carry) m_cfg = m_q[2:0];
            end else if (carry) begin
                m_state = 0;
                m_acc   = 0;
            end else begin
                m_state = 2;
            end
        end
        m_q      = ctrl_in;
        exp_wave = s_d1;
        s_d1     = s_d0;
        s_d0     = ideal(m_state, m_cfg, m_acc);
        exp_rom  = p_d0;
        p_d0     = 8'(m_acc >> 24);
        exp_wrap = carry;
        exp_run  = (m_state != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("wave_out", wave_out, exp_wave);
        check("rom_addr", rom_addr, exp_rom);
        check("phase_wrap", phase_wrap, exp_wrap);
        check("running", running, exp_run);
    endtask

    task automatic wait_addr(input logic [7:0] a, input int budget, output int n);
        n = 0;
        while (rom_addr !== a && n < budget) begin tick(); n++; end
        check("wait_rom_addr", rom_addr, a);
    endtask

    task automatic wait_wrap(input int budget, output int n);
        n = 0;
        do begin tick(); n++; end while (phase_wrap !== 1'b1 && n < budget);
        check("wait_phase_wrap", phase_wrap, 1'b1);
    endtask

    typedef struct {
        logic [3:0] ctrl;
        int         n;
        logic [7:0] wave;
        logic [7:0] addr;
        bit         wrap;
        bit         run;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n, nw;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

        // Coarse saw from stop, one full period, then drain to stop
        vecs[0] = '{4'b1111,   2, 8'h80, 8'h00, 1'b0, 1'b1};
        vecs[1] = '{4'b1111,   2, 8'h00, 8'h01, 1'b0, 1'b1};
        vecs[2] = '{4'b1111,  10, 8'h0A, 8'h0B, 1'b0, 1'b1};
        vecs[3] = '{4'b1111, 244, 8'hFE, 8'hFF, 1'b1, 1'b1};
        vecs[4] = '{4'b1111,   1, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{4'b1111,   1, 8'h00, 8'h01, 1'b0, 1'b1};
        vecs[6] = '{4'b0111, 253, 8'hFD, 8'hFE, 1'b0, 1'b1};
        vecs[7] = '{4'b0111,   1, 8'hFE, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{4'b0111,   1, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{4'b0111,   1, 8'h80, 8'h00, 1'b0, 1'b0};

        // Reset
        reset_n = 1'b0;
        ctrl_in = 4'd0;
        model_reset();
        repeat (5) @(negedge clk);
        check("reset_wave", wave_out, 8'h80);
        check("reset_addr", rom_addr, 8'h00);
        check("reset_running", running, 1'b0);
        check("reset_wrap", phase_wrap, 1'b0);
        reset_n = 1'b1;

        // Directed table
        for (int v = 0; v < 10; v++) begin
            ctrl_in = vecs[v].ctrl;
            repeat (vecs[v].n) tick();
            check($sformatf("vec%0d_wave", v), wave_out, vecs[v].wave);
            check($sformatf("vec%0d_addr", v), rom_addr, vecs[v].addr);
            check($sformatf("vec%0d_wrap", v), phase_wrap, vecs[v].wrap);
            check($sformatf("vec%0d_run", v), running, vecs[v].run);
        end

        // Sine coarse: two wraps within 600 clocks of starting
        ctrl_in = 4'b1100;
        nw = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (phase_wrap) nw++;
        end
        check("sine_wrap_count", nw, 2);

        // Deferred switch saw -> square
        ctrl_in = 4'b1111;
        wait_wrap(300, n);
        wait_addr(8'h40, 300, n);
        ctrl_in = 4'b1101;
        wait_wrap(300, n);
        check("defer_ticks_to_wrap", n, 191);
        check("defer_last_saw", wave_out, 8'hFE);
        tick();
        check("defer_saw_ff", wave_out, 8'hFF);
        tick();
        check("defer_first_square", wave_out, 8'h00);
        repeat (128) tick();
        check("defer_square_high", wave_out, 8'hFF);

        // Drain then rearm before the carry: no stop
        wait_wrap(300, n);
        ctrl_in = 4'b0101;
        repeat (50) tick();
        check("drain_running", running, 1'b1);
        ctrl_in = 4'b1101;
        repeat (400) tick();
        check("rearm_running", running, 1'b1);

        // Drain to stop
        wait_wrap(300, n);
        ctrl_in = 4'b0101;
        wait_wrap(300, n);
        check("drain_stop_running", running, 1'b0);
        tick();
        tick();
        check("drain_stop_mid", wave_out, 8'h80);

        // Async reset mid-run (triangle)
        ctrl_in = 4'b1110;
        wait_addr(8'h90, 300, n);
        #2 reset_n = 1'b0;
        #1;
        check("areset_wave", wave_out, 8'h80);
        check("areset_addr", rom_addr, 8'h00);
        check("areset_running", running, 1'b0);
        check("areset_wrap", phase_wrap, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        check("areset_resume", running, 1'b1);
        repeat (300) tick();

        // Randomized coarse control changes
        for (int s = 0; s < 40; s++) begin
            ctrl_in = 4'($urandom_range(0, 15)) | 4'b0100;
            repeat ($urandom_range(1, 300)) tick();
        end

        // Fine saw: exactly one wrap in 33000 clocks from stop
        ctrl_in = 4'b0100;
        n = 0;
        while (running !== 1'b0 && n < 600) begin tick(); n++; end
        check("pre_fine_stopped", running, 1'b0);
        ctrl_in = 4'b1011;
        nw = 0;
        for (int i = 0; i < 33000; i++) begin
            tick();
            if (phase_wrap) nw++;
        end
        check("fine_wrap_count", nw, 1);
        check("fine_running", running, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
